// File: rtl/hazard_pkg.sv
// Shared constants and helpers for the pipeline hazard scoreboard.
// Latency: n/a (declarations only).
// Backpressure: n/a.
//
// Contents: result-kind encodings, forwarding-select encodings, scoreboard
// counter width and the common countdown step used by every counter.
package hazard_pkg;

   // Result kind carried with a decode-stage instruction
   localparam logic [1:0] KIND_ALU  = 2'b00;
   localparam logic [1:0] KIND_LOAD = 2'b01;
   localparam logic [1:0] KIND_MDU  = 2'b10;

   // Forwarding mux selects for the execute-stage operands
   localparam logic [1:0] FWD_RF = 2'b00;
   localparam logic [1:0] FWD_W  = 2'b01;
   localparam logic [1:0] FWD_M  = 2'b10;

   // Countdown width; wide enough for the largest legal MDU latency (15)
   localparam int CNT_W = 4;

   // One cycle of countdown: saturate at zero, freeze while the pipe is held
   function automatic logic [CNT_W-1:0] countDown(input logic [CNT_W-1:0] cnt,
                                                  input logic             hold);
      if (hold || (cnt == '0)) begin
         return cnt;
      end
      return cnt - CNT_W'(1);
   endfunction

endpackage

// File: rtl/hazard_sb_entry.sv
// One scoreboard countdown: cycles until the owning register's result is forwardable.
// Latency: load visible the cycle after setEn; decrements by one per cycle.
// Backpressure: hold freezes the count (memory stall freezes the whole pipe).
//
// Ports:
//   clk, rst_n   clock, asynchronous active-low reset (clears count)
//   setEn/setVal load a new countdown; wins over the decrement in the same cycle
//   hold         freeze the count this cycle
//   count        current remaining cycles (0 = no pending writer)
module hazard_sb_entry
   import hazard_pkg::*;
(
   input  logic             clk,
   input  logic             rst_n,
   input  logic             setEn,
   input  logic [CNT_W-1:0] setVal,
   input  logic             hold,
   output logic [CNT_W-1:0] count
);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count <= '0;
      end else if (setEn) begin
         count <= setVal;
      end else begin
         count <= countDown(count, hold);
      end
   end

endmodule

// File: rtl/hazard_scoreboard.sv
// Pipeline hazard unit: operand forwarding, RAW/WAW/MDU-structural stalls, stall counter.
// Latency: forwarding and stall/flush outputs are combinational; scoreboard updates next edge.
// Backpressure: MemStall freezes E/M and all countdowns; decode is stalled or flushed on hazards.
//
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   Rs1D, Rs2D, RdD            decode-stage sources and destination
//   RegWriteD, KindD           decode write enable and result kind (ALU/LOAD/MDU)
//   Rs1E, Rs2E                 execute-stage sources (forwarding targets)
//   RdM, RegWriteM, RdW, RegWriteW  producers in memory and writeback stages
//   PCSrcE                     taken branch/jump resolved in execute
//   MemStall                   memory stage not ready; holds the back end
//   ForwardAE, ForwardBE       operand selects: 00 regfile, 01 W, 10 M
//   StallF/D/E/M, FlushD/E     pipeline control
//   StallCnt                   saturating count of cycles with StallD asserted
module hazard_scoreboard
   import hazard_pkg::*;
#(
   parameter int  NREG    = 32,
   parameter int  LD_LAT  = 1,
   parameter int  MDU_LAT = 4,
   localparam int RW      = $clog2(NREG)
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic [RW-1:0] Rs1D,
   input  logic [RW-1:0] Rs2D,
   input  logic [RW-1:0] RdD,
   input  logic          RegWriteD,
   input  logic [1:0]    KindD,
   input  logic [RW-1:0] Rs1E,
   input  logic [RW-1:0] Rs2E,
   input  logic [RW-1:0] RdM,
   input  logic [RW-1:0] RdW,
   input  logic          RegWriteM,
   input  logic          RegWriteW,
   input  logic          PCSrcE,
   input  logic          MemStall,
   output logic [1:0]    ForwardAE,
   output logic [1:0]    ForwardBE,
   output logic          StallF,
   output logic          StallD,
   output logic          StallE,
   output logic          StallM,
   output logic          FlushD,
   output logic          FlushE,
   output logic [31:0]   StallCnt
);

   logic [NREG-1:0][CNT_W-1:0] entryCnt;
   logic [CNT_W-1:0]           mduBusy;
   logic [CNT_W-1:0]           issueLat;
   logic [31:0]                stallCnt;
   logic                       rawHaz;
   logic                       wawHaz;
   logic                       structHaz;
   logic                       issue;
   logic                       mduIssue;

   // ---------------------------------------------------------------
   // Forwarding: the younger producer (M) shadows the older one (W).
   // x0 is never forwarded since its architectural value is always 0.
   // ---------------------------------------------------------------
   function automatic logic [1:0] fwdSel(input logic [RW-1:0] src);
      if ((src != '0) && RegWriteM && (src == RdM)) begin
         return FWD_M;
      end
      if ((src != '0) && RegWriteW && (src == RdW)) begin
         return FWD_W;
      end
      return FWD_RF;
   endfunction

   assign ForwardAE = fwdSel(Rs1E);
   assign ForwardBE = fwdSel(Rs2E);

   // ---------------------------------------------------------------
   // Hazard detection
   // ---------------------------------------------------------------
   assign rawHaz    = (entryCnt[Rs1D] != '0) || (entryCnt[Rs2D] != '0);
   assign wawHaz    = RegWriteD && (entryCnt[RdD] != '0);
   assign structHaz = (KindD == KIND_MDU) && (mduBusy != '0);

   // A redirect overrides a decode stall: the instruction in D is wrong-path
   // and gets flushed instead of held.
   assign StallD = (rawHaz || wawHaz || structHaz || MemStall) && !PCSrcE;
   assign StallF = StallD;
   assign StallE = MemStall;
   assign StallM = MemStall;
   assign FlushD = PCSrcE && !MemStall;
   // A hazard inserts a bubble into E while D is held.
   assign FlushE = (PCSrcE || rawHaz || wawHaz || structHaz) && !MemStall;

   // Only an instruction that actually leaves D may claim its destination;
   // this also keeps flushed wrong-path instructions off the scoreboard.
   assign issue    = !StallD && !FlushE && RegWriteD && (RdD != '0);
   assign mduIssue = issue && (KindD == KIND_MDU);

   always_comb begin
      issueLat = '0;
      case (KindD)
         KIND_LOAD: issueLat = CNT_W'(LD_LAT);
         KIND_MDU:  issueLat = CNT_W'(MDU_LAT);
         default:   issueLat = '0;
      endcase
   end

   // ---------------------------------------------------------------
   // Scoreboard: x0 is hard-wired idle, one countdown per other register
   // ---------------------------------------------------------------
   assign entryCnt[0] = '0;

   for (genvar i = 1; i < NREG; i++) begin : gEntry
      hazard_sb_entry uEntry (
         .clk    (clk),
         .rst_n  (rst_n),
         .setEn  (issue && (RdD == RW'(i))),
         .setVal (issueLat),
         .hold   (MemStall),
         .count  (entryCnt[i])
      );
   end

   // ---------------------------------------------------------------
   // MDU occupancy: the unit is not pipelined, so a second MDU op must
   // wait for the first to drain even if it writes another register.
   // ---------------------------------------------------------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mduBusy <= '0;
      end else if (mduIssue) begin
         mduBusy <= CNT_W'(MDU_LAT);
      end else begin
         mduBusy <= countDown(mduBusy, MemStall);
      end
   end

   // ---------------------------------------------------------------
   // Stall statistics, saturating
   // ---------------------------------------------------------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stallCnt <= '0;
      end else if (StallD && (stallCnt != '1)) begin
         stallCnt <= stallCnt + 32'd1;
      end
   end

   assign StallCnt = stallCnt;

endmodule

// File: doc/hazard_scoreboard.md
HAZARD_SCOREBOARD -- requirements
Module: hazard_scoreboard

Interface
REQ-001 SHALL have parameter NREG, default 32, number of architectural registers.
REQ-002 SHALL have parameter LD_LAT, default 1, load-use stall cycles (legal 1..7).
REQ-003 SHALL have parameter MDU_LAT, default 4, mul/div-use stall cycles (legal 1..15).
REQ-004 SHALL derive localparam RW = clog2(NREG) as the register-index width.
REQ-005 SHALL have port clk, input, 1, the single clock; rising edge.
REQ-006 SHALL have port rst_n, input, 1, reset, asynchronous and active-low.
REQ-007 SHALL have ports Rs1D, Rs2D, RdD, input, RW each, decode-stage source and destination indices.
REQ-008 SHALL have ports RegWriteD, input, 1, and KindD, input, 2, decode write enable and result kind (ALU/LOAD/MDU).
REQ-009 SHALL have ports Rs1E, Rs2E, input, RW each, and RdM, RdW, input, RW each.
REQ-010 SHALL have ports RegWriteM, RegWriteW, PCSrcE, MemStall, input, 1 each.
REQ-011 SHALL have ports ForwardAE, ForwardBE, output, 2 each: 00 register file, 01 W result, 10 M result.
REQ-012 SHALL have ports StallF, StallD, StallE, StallM, FlushD, FlushE, output, 1 each.
REQ-013 SHALL have port StallCnt, output, 32, saturating count of cycles with StallD asserted.

Function
REQ-014 Forwarding SHALL be combinational: M match wins over W match; match requires RegWrite of that stage and source index non-zero.
REQ-015 Scoreboard SHALL hold one 4-bit countdown per register; entry 0 SHALL be constant 0.
REQ-016 Issue SHALL mean !StallD && !FlushE && RegWriteD && RdD != 0.
REQ-017 On issue, entry[RdD] SHALL load 0 for ALU, LD_LAT for LOAD, MDU_LAT for MDU, at the next clock edge.
REQ-018 All non-zero entries SHALL decrement by 1 each cycle unless MemStall=1, in which case all SHALL hold.
REQ-019 A set and a decrement of the same entry in the same cycle SHALL resolve to the set value.
REQ-020 The RAW hazard SHALL be entry[Rs1D]!=0 or entry[Rs2D]!=0.
REQ-021 The WAW hazard SHALL be RegWriteD with entry[RdD]!=0.
REQ-022 MDU busy SHALL be an internal 4-bit counter loaded with MDU_LAT on an MDU issue and decremented like the entries; KindD=MDU while it is non-zero SHALL be a structural hazard.
REQ-023 StallF and StallD SHALL equal (RAW or WAW or structural or MemStall) and !PCSrcE.
REQ-024 StallE and StallM SHALL equal MemStall.
REQ-025 FlushD SHALL equal PCSrcE && !MemStall.
REQ-026 FlushE SHALL equal (PCSrcE or RAW or WAW or structural) && !MemStall.
REQ-027 A flushed decode instruction SHALL never set a scoreboard entry, per REQ-016.
REQ-028 StallCnt SHALL increment once per cycle with StallD=1 and SHALL hold at 0xFFFFFFFF.

Reset
REQ-029 While rst_n=0, all scoreboard entries, the MDU busy counter and StallCnt SHALL be 0 immediately, without waiting for a clock edge.
REQ-030 After reset, all stall and flush outputs SHALL be 0 until an instruction issues.
REQ-031 Reset mid-countdown SHALL abandon all pending entries; no stall SHALL persist after release.

Structure
REQ-032 Package hazard_pkg SHALL define the KIND_ALU=00, KIND_LOAD=01 and KIND_MDU=10 constants.
REQ-033 Package hazard_pkg SHALL also define the FWD_RF=00, FWD_W=01 and FWD_M=10 constants.
REQ-034 Sub-module hazard_sb_entry SHALL implement one countdown entry (load, decrement, hold) and SHALL be instantiated for NREG-1 entries.
REQ-035 The top level SHALL contain the forwarding logic, hazard detection, MDU busy counter and StallCnt.

Verification
REQ-036 The bench SHALL cover: LOAD x5 issued, next D reads x5, LD_LAT=1 -> StallD=1 and FlushE=1 for exactly 1 cycle; then ForwardAE=01.
REQ-037 The bench SHALL cover: MDU to x7, MDU_LAT=4, dependent op in D -> StallD=1 for 4 cycles; StallCnt rises by 4.
REQ-038 The bench SHALL cover: two back-to-back MDU ops to x8 and x9 -> the second stalls until the busy counter is 0.
REQ-039 The bench SHALL cover: LOAD in D with PCSrcE=1 -> no entry set, and the next instruction reading that Rd has no stall.
REQ-040 The bench SHALL cover: MemStall=1 for 3 cycles during a LOAD countdown -> entry holds, and all four Stall outputs are 1.
REQ-041 The bench SHALL cover: rst_n low while entry[x3]=3 -> entries clear immediately; after release, a read of x3 does not stall; a RdM=RdW=x0 match gives ForwardAE=00.
